pb_audio_port: RTL and testbench

- PicoBlaze port-bus responder: decodes the CPU's port_id/strobes and exposes the audio sample FIFOs, control and status to firmware.
- Contains a 16-bit play FIFO (CPU writes it, codec side drains it) and a 16-bit record FIFO (codec side fills it, CPU reads it).
- Drives the CPU interrupt input and clears it on interrupt_ack.
- Sits between the PicoBlaze wrapper and the codec serializer/deserializer.

---
 rtl/pb_audio_pkg.sv | 36 +++
 rtl/pb_sample_fifo.sv | 62 ++++++
 rtl/pb_audio_port.sv | 156 +++++++++++++++
 tb/tb_pb_audio_port.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pb_audio_pkg.sv
// Shared constants for the PicoBlaze audio port: register offsets, CTRL/STATUS
// bit positions and the sample width.
package pb_audio_pkg;

    localparam int SAMPLE_W = 16;

    // Read offsets
    localparam logic [2:0] OFF_STATUS     = 3'd0;
    localparam logic [2:0] OFF_REC_LO     = 3'd1;
    localparam logic [2:0] OFF_REC_HI     = 3'd2;
    localparam logic [2:0] OFF_PLAY_COUNT = 3'd3;
    localparam logic [2:0] OFF_REC_COUNT  = 3'd4;
    localparam logic [2:0] OFF_CTRL_RD    = 3'd5;

    // Write offsets
    localparam logic [2:0] OFF_PLAY_LO    = 3'd0;
    localparam logic [2:0] OFF_PLAY_HI    = 3'd1;
    localparam logic [2:0] OFF_CTRL       = 3'd2;
    localparam logic [2:0] OFF_FLAG_CLR   = 3'd3;

    localparam int CTRL_PLAY_EN     = 0;
    localparam int CTRL_REC_EN      = 1;
    localparam int CTRL_IRQ_PLAY_EN = 2;
    localparam int CTRL_IRQ_REC_EN  = 3;

    localparam int ST_PLAY_EMPTY = 0;
    localparam int ST_PLAY_FULL  = 1;
    localparam int ST_REC_EMPTY  = 2;
    localparam int ST_REC_FULL   = 3;
    localparam int ST_PLAY_OVF   = 4;
    localparam int ST_REC_OVF    = 5;

    localparam int CLR_PLAY_OVF = 0;
    localparam int CLR_REC_OVF  = 1;

endpackage

// File: rtl/pb_sample_fifo.sv
// Single-clock sample FIFO with combinational head output. A pop on a full FIFO
// frees the slot for a same-cycle push; a pop on an empty FIFO is ignored.
module pb_sample_fifo #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] mem_q [0:(1<<AW)-1];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_eff, pop_eff;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        pop_eff  = pop & ~empty;
        push_eff = push & (~full | pop_eff);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_eff) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_eff)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_eff, pop_eff})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_eff) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/pb_audio_port.sv
// PicoBlaze port-bus responder exposing play/record sample FIFOs, control,
// status flags and an edge-triggered interrupt to firmware.
module pb_audio_port
    import pb_audio_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR  = 8'h10,
    parameter int         FIFO_AW    = 4,
    parameter int         LOW_WATER  = 4,
    parameter int         HIGH_WATER = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          port_id,
    input  logic                write_strobe,
    input  logic [7:0]          out_port,
    input  logic                read_strobe,
    output logic [7:0]          in_port,
    output logic                interrupt,
    input  logic                interrupt_ack,
    output logic [SAMPLE_W-1:0] play_sample,
    output logic                play_valid,
    input  logic                play_ready,
    input  logic [SAMPLE_W-1:0] rec_sample,
    input  logic                rec_strobe
);

    localparam logic [FIFO_AW:0] LOW_WATER_C  = (FIFO_AW+1)'(LOW_WATER);
    localparam logic [FIFO_AW:0] HIGH_WATER_C = (FIFO_AW+1)'(HIGH_WATER);

    logic                hit, wr_hit, rd_hit;
    logic [2:0]          off;
    logic [7:0]          ctrl_q, ctrl_d;
    logic [7:0]          play_lo_q, play_lo_d;
    logic                play_ovf_q, play_ovf_d;
    logic                rec_ovf_q, rec_ovf_d;
    logic [7:0]          in_port_q, in_port_d;
    logic                cond_q, cond_d;
    logic                irq_q, irq_d;
    logic [7:0]          status;

    logic                play_push, play_pop, play_full, play_empty;
    logic [FIFO_AW:0]    play_count;
    logic [SAMPLE_W-1:0] play_head;
    logic                rec_push, rec_pop, rec_full, rec_empty;
    logic [FIFO_AW:0]    rec_count;
    logic [SAMPLE_W-1:0] rec_head;

    assign hit    = (port_id[7:3] == BASE_ADDR[7:3]);
    assign off    = port_id[2:0];
    assign wr_hit = write_strobe & hit;
    assign rd_hit = read_strobe & hit;

    assign play_push = wr_hit & (off == OFF_PLAY_HI);
    assign play_pop  = play_valid & play_ready;
    assign rec_push  = rec_strobe & ctrl_q[CTRL_REC_EN];
    assign rec_pop   = rd_hit & (off == OFF_REC_HI) & ~rec_empty;

    assign play_valid  = ctrl_q[CTRL_PLAY_EN] & ~play_empty;
    assign play_sample = play_head;
    assign in_port     = in_port_q;
    assign interrupt   = irq_q;

    pb_sample_fifo #(.DW(SAMPLE_W), .AW(FIFO_AW)) u_play_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (play_push),
        .pop   (play_pop),
        .din   ({out_port, play_lo_q}),
        .dout  (play_head),
        .full  (play_full),
        .empty (play_empty),
        .count (play_count)
    );

    pb_sample_fifo #(.DW(SAMPLE_W), .AW(FIFO_AW)) u_rec_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rec_push),
        .pop   (rec_pop),
        .din   (rec_sample),
        .dout  (rec_head),
        .full  (rec_full),
        .empty (rec_empty),
        .count (rec_count)
    );

    always_comb begin
        status                = '0;
        status[ST_PLAY_EMPTY] = play_empty;
        status[ST_PLAY_FULL]  = play_full;
        status[ST_REC_EMPTY]  = rec_empty;
        status[ST_REC_FULL]   = rec_full;
        status[ST_PLAY_OVF]   = play_ovf_q;
        status[ST_REC_OVF]    = rec_ovf_q;
    end

    always_comb begin
        in_port_d = 8'h00;
        if (hit) begin
            case (off)
                OFF_STATUS:     in_port_d = status;
                OFF_REC_LO:     in_port_d = rec_empty ? 8'h00 : rec_head[7:0];
                OFF_REC_HI:     in_port_d = rec_empty ? 8'h00 : rec_head[15:8];
                OFF_PLAY_COUNT: in_port_d = 8'(play_count);
                OFF_REC_COUNT:  in_port_d = 8'(rec_count);
                OFF_CTRL_RD:    in_port_d = ctrl_q;
                default:        in_port_d = 8'h00;
            endcase
        end
    end

    always_comb begin
        ctrl_d     = ctrl_q;
        play_lo_d  = play_lo_q;
        play_ovf_d = play_ovf_q;
        rec_ovf_d  = rec_ovf_q;
        if (wr_hit && off == OFF_PLAY_LO) play_lo_d = out_port;
        if (wr_hit && off == OFF_CTRL)    ctrl_d    = out_port;
        if (wr_hit && off == OFF_FLAG_CLR) begin
            if (out_port[CLR_PLAY_OVF]) play_ovf_d = 1'b0;
            if (out_port[CLR_REC_OVF])  rec_ovf_d  = 1'b0;
        end
        // Overflow set comes last so it wins over a same-cycle clear
        if (play_push && play_full && !play_pop) play_ovf_d = 1'b1;
        if (rec_push && rec_full && !rec_pop)    rec_ovf_d  = 1'b1;
    end

    always_comb begin
        cond_d = (ctrl_q[CTRL_IRQ_PLAY_EN] & ctrl_q[CTRL_PLAY_EN] & (play_count <= LOW_WATER_C))
               | (ctrl_q[CTRL_IRQ_REC_EN] & ctrl_q[CTRL_REC_EN] & (rec_count >= HIGH_WATER_C));
        irq_d = irq_q;
        if (interrupt_ack)      irq_d = 1'b0;
        if (cond_d && !cond_q)  irq_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q     <= '0;
            play_lo_q  <= '0;
            play_ovf_q <= 1'b0;
            rec_ovf_q  <= 1'b0;
            in_port_q  <= '0;
            cond_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            play_lo_q  <= play_lo_d;
            play_ovf_q <= play_ovf_d;
            rec_ovf_q  <= rec_ovf_d;
            in_port_q  <= in_port_d;
            cond_q     <= cond_d;
            irq_q      <= irq_d;
        end
    end

endmodule

// File: tb/tb_pb_audio_port.sv
// Directed bench for pb_audio_port: reset, play path, record overflow,
// full-FIFO push/pop, interrupt edge/ack and address decode.
module tb_pb_audio_port;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  port_id;
    logic        write_strobe;
    logic [7:0]  out_port;
    logic        read_strobe;
    logic [7:0]  in_port;
    logic        interrupt;
    logic        interrupt_ack;
    logic [15:0] play_sample;
    logic        play_valid;
    logic        play_ready;
    logic [15:0] rec_sample;
    logic        rec_strobe;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pb_audio_port dut (
        .clk           (clk),
        .reset         (reset),
        .port_id       (port_id),
        .write_strobe  (write_strobe),
        .out_port      (out_port),
        .read_strobe   (read_strobe),
        .in_port       (in_port),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack),
        .play_sample   (play_sample),
        .play_valid    (play_valid),
        .play_ready    (play_ready),
        .rec_sample    (rec_sample),
        .rec_strobe    (rec_strobe)
    );

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] addr, input logic [7:0] data);
        port_id = addr; out_port = data; write_strobe = 1'b1;
        @(posedge clk); #1;
        write_strobe = 1'b0; port_id = 8'h00;
    endtask

    task automatic cpu_read(input logic [7:0] addr, output logic [7:0] data);
        port_id = addr;
        @(posedge clk); #1;
        read_strobe = 1'b1;
        data = in_port;
        @(posedge clk); #1;
        read_strobe = 1'b0; port_id = 8'h00;
    endtask

    task automatic play_push(input logic [15:0] v);
        cpu_write(8'h10, v[7:0]);
        cpu_write(8'h11, v[15:8]);
    endtask

    task automatic rec_pulse(input logic [15:0] v);
        rec_sample = v; rec_strobe = 1'b1;
        @(posedge clk); #1;
        rec_strobe = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        do_reset();
        tests_run++; if (in_port !== 8'h00) begin tests_failed++; $display("FAIL reset_in_port: got %h want 00", in_port); end
        tests_run++; if (interrupt !== 1'b0) begin tests_failed++; $display("FAIL reset_irq: got %b want 0", interrupt); end
        tests_run++; if (play_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_play_valid: got %b want 0", play_valid); end
        cpu_read(8'h10, d);
        tests_run++; if (d !== 8'h05) begin tests_failed++; $display("FAIL reset_status: got %h want 05", d); end
        $display("[TB] reset: status=%h irq=%b", d, interrupt);
    endtask

    task automatic test_play();
        logic [7:0] d;
        do_reset();
        cpu_write(8'h10, 8'h34);
        cpu_write(8'h11, 8'h12);
        cpu_write(8'h12, 8'h01);
        tests_run++; if (play_valid !== 1'b1) begin tests_failed++; $display("FAIL play_valid: got %b want 1", play_valid); end
        tests_run++; if (play_sample !== 16'h1234) begin tests_failed++; $display("FAIL play_sample: got %h want 1234", play_sample); end
        cpu_read(8'h13, d);
        tests_run++; if (d !== 8'h01) begin tests_failed++; $display("FAIL play_count1: got %h want 01", d); end
        play_ready = 1'b1;
        @(posedge clk); #1;
        play_ready = 1'b0;
        tests_run++; if (play_valid !== 1'b0) begin tests_failed++; $display("FAIL play_drained: got %b want 0", play_valid); end
        cpu_write(8'h12, 8'hF1);
        cpu_read(8'h15, d);
        tests_run++; if (d !== 8'hF1) begin tests_failed++; $display("FAIL ctrl_readback: got %h want f1", d); end
        $display("[TB] play: sample popped, ctrl=%h", d);
    endtask

    task automatic test_rec_overflow();
        logic [7:0] d;
        do_reset();
        cpu_write(8'h12, 8'h02);
        for (int i = 0; i < 17; i++) rec_pulse(16'(i));
        cpu_read(8'h14, d);
        tests_run++; if (d !== 8'h10) begin tests_failed++; $display("FAIL rec_count_full: got %h want 10", d); end
        cpu_read(8'h10, d);
        tests_run++; if (d !== 8'h29) begin tests_failed++; $display("FAIL rec_status_ovf: got %h want 29", d); end
        // overflow and FLAG_CLR on the same edge: the set must survive
        port_id = 8'h13; out_port = 8'h02; write_strobe = 1'b1;
        rec_sample = 16'h0011; rec_strobe = 1'b1;
        @(posedge clk); #1;
        write_strobe = 1'b0; rec_strobe = 1'b0; port_id = 8'h00;
        cpu_read(8'h10, d);
        tests_run++; if (d !== 8'h29) begin tests_failed++; $display("FAIL rec_set_wins: got %h want 29", d); end
        cpu_read(8'h11, d);
        tests_run++; if (d !== 8'h00) begin tests_failed++; $display("FAIL rec_lo0: got %h want 00", d); end
        cpu_read(8'h12, d);
        tests_run++; if (d !== 8'h00) begin tests_failed++; $display("FAIL rec_hi0: got %h want 00", d); end
        cpu_read(8'h14, d);
        tests_run++; if (d !== 8'h0F) begin tests_failed++; $display("FAIL rec_count_pop: got %h want 0f", d); end
        cpu_read(8'h11, d);
        tests_run++; if (d !== 8'h01) begin tests_failed++; $display("FAIL rec_lo1: got %h want 01", d); end
        cpu_read(8'h12, d);
        cpu_write(8'h13, 8'h02);
        cpu_read(8'h10, d);
        tests_run++; if (d !== 8'h01) begin tests_failed++; $display("FAIL rec_flag_clr: got %h want 01", d); end
        $display("[TB] rec overflow: status after clear=%h", d);
    endtask

    task automatic test_full_push_pop();
        logic [7:0] d;
        do_reset();
        for (int i = 0; i < 16; i++) play_push(16'h0100 + 16'(i));
        cpu_read(8'h13, d);
        tests_run++; if (d !== 8'h10) begin tests_failed++; $display("FAIL play_count_full: got %h want 10", d); end
        cpu_write(8'h12, 8'h01);
        tests_run++; if (play_sample !== 16'h0100) begin tests_failed++; $display("FAIL play_head0: got %h want 0100", play_sample); end
        cpu_write(8'h10, 8'hAA);
        port_id = 8'h11; out_port = 8'hBB; write_strobe = 1'b1; play_ready = 1'b1;
        @(posedge clk); #1;
        write_strobe = 1'b0; play_ready = 1'b0; port_id = 8'h00;
        tests_run++; if (play_sample !== 16'h0101) begin tests_failed++; $display("FAIL play_head1: got %h want 0101", play_sample); end
        cpu_read(8'h13, d);
        tests_run++; if (d !== 8'h10) begin tests_failed++; $display("FAIL play_count_pushpop: got %h want 10", d); end
        cpu_read(8'h10, d);
        tests_run++; if (d !== 8'h06) begin tests_failed++; $display("FAIL play_no_ovf: got %h want 06", d); end
        cpu_write(8'h12, 8'h00);
        cpu_write(8'h11, 8'hCC);
        cpu_read(8'h10, d);
        tests_run++; if (d !== 8'h16) begin tests_failed++; $display("FAIL play_ovf_set: got %h want 16", d); end
        cpu_write(8'h13, 8'h01);
        cpu_read(8'h10, d);
        tests_run++; if (d !== 8'h06) begin tests_failed++; $display("FAIL play_ovf_clr: got %h want 06", d); end
        $display("[TB] full push/pop: status=%h", d);
    endtask

    task automatic test_interrupt();
        do_reset();
        for (int i = 0; i < 5; i++) play_push(16'h0200 + 16'(i));
        cpu_write(8'h12, 8'h0B);
        repeat (2) @(posedge clk); #1;
        tests_run++; if (interrupt !== 1'b0) begin tests_failed++; $display("FAIL irq_idle: got %b want 0", interrupt); end
        for (int i = 0; i < 12; i++) rec_pulse(16'hA500 + 16'(i));
        tests_run++; if (interrupt !== 1'b0) begin tests_failed++; $display("FAIL irq_latency: got %b want 0", interrupt); end
        @(posedge clk); #1;
        tests_run++; if (interrupt !== 1'b1) begin tests_failed++; $display("FAIL irq_rise: got %b want 1", interrupt); end
        repeat (3) @(posedge clk); #1;
        tests_run++; if (interrupt !== 1'b1) begin tests_failed++; $display("FAIL irq_hold: got %b want 1", interrupt); end
        interrupt_ack = 1'b1;
        @(posedge clk); #1;
        interrupt_ack = 1'b0;
        tests_run++; if (interrupt !== 1'b0) begin tests_failed++; $display("FAIL irq_ack: got %b want 0", interrupt); end
        rec_pulse(16'hA50C);
        repeat (2) @(posedge clk); #1;
        tests_run++; if (interrupt !== 1'b0) begin tests_failed++; $display("FAIL irq_no_retrigger: got %b want 0", interrupt); end
        $display("[TB] interrupt: rise after count 12, cleared by ack");
    endtask

    task automatic test_decode();
        logic [7:0] d;
        do_reset();
        cpu_read(8'h20, d);
        tests_run++; if (d !== 8'h00) begin tests_failed++; $display("FAIL decode_miss: got %h want 00", d); end
        cpu_read(8'h16, d);
        tests_run++; if (d !== 8'h00) begin tests_failed++; $display("FAIL offset6: got %h want 00", d); end
        cpu_read(8'h12, d);
        tests_run++; if (d !== 8'h00) begin tests_failed++; $display("FAIL rec_hi_empty: got %h want 00", d); end
        cpu_read(8'h14, d);
        tests_run++; if (d !== 8'h00) begin tests_failed++; $display("FAIL rec_count_empty: got %h want 00", d); end
        $display("[TB] decode: miss and empty reads return 00");
    endtask

    initial begin
        reset = 1'b1; port_id = 8'h00; write_strobe = 1'b0; out_port = 8'h00;
        read_strobe = 1'b0; interrupt_ack = 1'b0; play_ready = 1'b0;
        rec_sample = 16'h0000; rec_strobe = 1'b0;
        #1;
        test_reset();
        test_play();
        test_rec_overflow();
        test_full_push_pop();
        test_interrupt();
        test_decode();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
